// File: rtl/core_seq.sv
// Multi-cycle control sequencer: fetch, decode, execute, memory and writeback
// with trap commit, a bus-wait timeout and a sticky halt.
module core_seq #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        if_req,
  input  logic        if_ack,
  output logic        ir_we,
  input  logic        dec_mem_read,
  input  logic        dec_mem_write,
  input  logic        dec_reg_write,
  input  logic        dec_is_csr,
  input  logic        dec_ebreak,
  input  logic        dec_ecall,
  input  logic        dec_mret,
  input  logic        dec_illegal,
  output logic        ls_req,
  input  logic        ls_ack,
  output logic        rf_we,
  output logic        csr_we,
  output logic        pc_we,
  output logic        trap_we,
  output logic        halt,
  output logic [1:0]  halt_code,
  output logic [31:0] retired,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [1:0]  CODE_EBREAK  = 2'd0;
  localparam logic [1:0]  CODE_TIMEOUT = 2'd1;
  localparam logic [31:0] TIMEOUT_LIM  = 32'(TIMEOUT);

  state_t     state_reg;
  logic [7:0] wait_cnt_reg;
  logic [7:0] wait_inc;
  logic       wait_expired;

  assign wait_inc     = (wait_cnt_reg == 8'hFF) ? 8'hFF : wait_cnt_reg + 8'd1;
  assign wait_expired = ({24'd0, wait_inc} >= TIMEOUT_LIM);
  assign ir_we        = if_req & if_ack;
  assign state        = state_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_FETCH;
      wait_cnt_reg <= '0;
      retired      <= '0;
      halt         <= 1'b0;
      halt_code    <= CODE_EBREAK;
      if_req       <= 1'b0;
      ls_req       <= 1'b0;
      rf_we        <= 1'b0;
      csr_we       <= 1'b0;
      pc_we        <= 1'b0;
      trap_we      <= 1'b0;
    end else begin
      if_req  <= 1'b0;
      ls_req  <= 1'b0;
      rf_we   <= 1'b0;
      csr_we  <= 1'b0;
      pc_we   <= 1'b0;
      trap_we <= 1'b0;
      case (state_reg)
        S_FETCH: begin
          // if_req is low only in the first cycle out of reset
          if (!if_req) begin
            if_req <= 1'b1;
          end else if (if_ack) begin
            state_reg <= S_DECODE;
          end else if (wait_expired) begin
            state_reg <= S_HALT;
            halt      <= 1'b1;
            halt_code <= CODE_TIMEOUT;
          end else begin
            if_req       <= 1'b1;
            wait_cnt_reg <= wait_inc;
          end
        end
        S_DECODE: begin
          if (dec_ebreak) begin
            state_reg <= S_HALT;
            halt      <= 1'b1;
            halt_code <= CODE_EBREAK;
          end else if (dec_ecall || dec_illegal) begin
            state_reg <= S_TRAP;
            trap_we   <= 1'b1;
            pc_we     <= 1'b1;
          end else if (dec_mret) begin
            // mret target selection lives in the PC datapath
            state_reg <= S_EXEC;
          end else begin
            state_reg <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (dec_mem_read || dec_mem_write) begin
            state_reg    <= S_MEM;
            ls_req       <= 1'b1;
            wait_cnt_reg <= '0;
          end else begin
            state_reg <= S_WB;
            pc_we     <= 1'b1;
            rf_we     <= dec_reg_write;
            csr_we    <= dec_is_csr;
          end
        end
        S_MEM: begin
          if (ls_ack) begin
            state_reg <= S_WB;
            pc_we     <= 1'b1;
            rf_we     <= dec_reg_write;
            csr_we    <= dec_is_csr;
          end else if (wait_expired) begin
            state_reg <= S_HALT;
            halt      <= 1'b1;
            halt_code <= CODE_TIMEOUT;
          end else begin
            ls_req       <= 1'b1;
            wait_cnt_reg <= wait_inc;
          end
        end
        S_WB, S_TRAP: begin
          retired      <= retired + 32'd1;
          state_reg    <= S_FETCH;
          if_req       <= 1'b1;
          wait_cnt_reg <= '0;
        end
        S_HALT: begin
          state_reg <= S_HALT;
        end
        default: begin
          state_reg    <= S_FETCH;
          if_req       <= 1'b1;
          wait_cnt_reg <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_seq.sv
// Table-driven bench for core_seq: one instruction per vector, plus hand
// sequences for halt absorption and reset in the middle of a memory wait.
module tb_core_seq;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_ack, ir_we;
  logic [7:0]  dec_bus;  // {mem_read, mem_write, reg_write, is_csr, ebreak, ecall, mret, illegal}
  logic        ls_req, ls_ack;
  logic        rf_we, csr_we, pc_we, trap_we, halt;
  logic [1:0]  halt_code;
  logic [31:0] retired;
  logic [2:0]  state;

  core_seq #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_ack(if_ack), .ir_we(ir_we),
    .dec_mem_read(dec_bus[7]), .dec_mem_write(dec_bus[6]),
    .dec_reg_write(dec_bus[5]), .dec_is_csr(dec_bus[4]),
    .dec_ebreak(dec_bus[3]), .dec_ecall(dec_bus[2]),
    .dec_mret(dec_bus[1]), .dec_illegal(dec_bus[0]),
    .ls_req(ls_req), .ls_ack(ls_ack),
    .rf_we(rf_we), .csr_we(csr_we), .pc_we(pc_we), .trap_we(trap_we),
    .halt(halt), .halt_code(halt_code), .retired(retired), .state(state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_ret  = 0;

  typedef struct {
    string      name;
    int         if_dly;
    int         ls_dly;
    logic [7:0] dec;
    bit         noise;
    int         cyc, ir, pc, rf, cs, trp, lsq, ret;
    bit         hlt;
    int         code;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; if_ack = 1'b0; ls_ack = 1'b0; dec_bus = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    exp_ret = 0;
  endtask

  // Entered and left at a falling edge, with the DUT in its first fetch cycle.
  task automatic run_vec(input vec_t v);
    int cyc = 0, fetch_n = 0, ls_n = 0, bad = 0;
    int n_ir = 0, n_pc = 0, n_rf = 0, n_cs = 0, n_tr = 0, n_lsq = 0;
    bit left = 1'b0, done = 1'b0;
    if (halt) do_reset();
    dec_bus = v.dec;
    while (!done) begin
      if (halt || (state == 3'd0 && left) || cyc >= 40) begin
        done = 1'b1;
      end else begin
        if (if_req) fetch_n++;
        if (ls_req) ls_n++;
        if_ack = if_req ? (fetch_n == v.if_dly + 1) : v.noise;
        ls_ack = ls_req ? (ls_n == v.ls_dly + 1) : v.noise;
        #1;
        if (state != 3'd0) left = 1'b1;
        if (ir_we)   n_ir++;
        if (pc_we)   n_pc++;
        if (rf_we)   n_rf++;
        if (csr_we)  n_cs++;
        if (trap_we) n_tr++;
        if (ls_req)  n_lsq++;
        if (ir_we && (pc_we || trap_we))          bad++;
        if ((rf_we || csr_we) && state != 3'd4)  bad++;
        if (trap_we && state != 3'd5)            bad++;
        cyc++;
        @(posedge clk); #1;
        if_ack = 1'b0; ls_ack = 1'b0;
        @(negedge clk);
      end
    end
    dec_bus = '0;
    exp_ret = exp_ret + v.ret;
    $display("vec %s: %0d cycles, retired %0d, halt %0d", v.name, cyc, retired, halt);
    check({v.name, "_cycles"}, cyc, v.cyc);
    check({v.name, "_ir_we"}, n_ir, v.ir);
    check({v.name, "_pc_we"}, n_pc, v.pc);
    check({v.name, "_rf_we"}, n_rf, v.rf);
    check({v.name, "_csr_we"}, n_cs, v.cs);
    check({v.name, "_trap_we"}, n_tr, v.trp);
    check({v.name, "_ls_req_cycles"}, n_lsq, v.lsq);
    check({v.name, "_retired"}, retired, exp_ret);
    check({v.name, "_halt"}, halt, v.hlt);
    check({v.name, "_halt_code"}, halt_code, v.code);
    check({v.name, "_if_req_end"}, if_req, !v.hlt);
    check({v.name, "_ls_req_end"}, ls_req, 0);
    check({v.name, "_exclusive"}, bad, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    int strobes;
    int k;
    rst_n = 1'b0; if_ack = 1'b0; ls_ack = 1'b0; dec_bus = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {if_req, ir_we, ls_req, rf_we, csr_we, pc_we, trap_we, halt, halt_code, state}, 0);
    check("rst_retired", retired, 0);
    rst_n = 1'b1; #1;
    check("release_if_req_before_edge", if_req, 0);
    @(posedge clk); @(negedge clk);
    check("first_cycle_if_req", if_req, 1);
    check("first_cycle_state", state, 0);

    //                  name             ifd lsd  dec          nz cyc ir pc rf cs tr lsq ret hlt code
    vecs.push_back(vec_t'{"alu",           0,  0, 8'b0010_0000, 0, 4, 1, 1, 1, 0, 0, 0, 1, 0, 0});
    vecs.push_back(vec_t'{"csr_wait2",     2,  0, 8'b0011_0000, 0, 6, 1, 1, 1, 1, 0, 0, 1, 0, 0});
    vecs.push_back(vec_t'{"load_ack4th",   0,  3, 8'b1010_0000, 0, 8, 1, 1, 1, 0, 0, 4, 1, 0, 0});
    vecs.push_back(vec_t'{"store",         0,  0, 8'b0100_0000, 0, 5, 1, 1, 0, 0, 0, 1, 1, 0, 0});
    vecs.push_back(vec_t'{"illegal",       0,  0, 8'b1010_0001, 0, 3, 1, 1, 0, 0, 1, 0, 1, 0, 0});
    vecs.push_back(vec_t'{"ecall",         1,  0, 8'b0000_0100, 0, 4, 1, 1, 0, 0, 1, 0, 1, 0, 0});
    vecs.push_back(vec_t'{"mret",          0,  0, 8'b0000_0010, 0, 4, 1, 1, 0, 0, 0, 0, 1, 0, 0});
    vecs.push_back(vec_t'{"alu_ack_noise", 0,  0, 8'b0010_0000, 1, 4, 1, 1, 1, 0, 0, 0, 1, 0, 0});
    vecs.push_back(vec_t'{"fetch_ack4th",  3,  0, 8'b0010_0000, 0, 7, 1, 1, 1, 0, 0, 0, 1, 0, 0});
    vecs.push_back(vec_t'{"load_timeout",  0, 99, 8'b1010_0000, 0, 7, 1, 0, 0, 0, 0, 4, 0, 1, 1});
    vecs.push_back(vec_t'{"fetch_timeout",99,  0, 8'b0010_0000, 0, 4, 0, 0, 0, 0, 0, 0, 0, 1, 1});
    vecs.push_back(vec_t'{"ebreak",        0,  0, 8'b1000_1101, 0, 2, 1, 0, 0, 0, 0, 0, 0, 1, 0});

    foreach (vecs[i]) run_vec(vecs[i]);

    // Halted after ebreak: acks must be ignored and nothing may move.
    strobes = 0;
    for (int c = 0; c < 4; c++) begin
      if_ack = 1'b1; ls_ack = 1'b1; #1;
      if (ir_we | pc_we | rf_we | csr_we | trap_we | if_req | ls_req) strobes++;
      @(posedge clk); @(negedge clk);
    end
    if_ack = 1'b0; ls_ack = 1'b0;
    $display("seq halt_absorb: state %0d, retired %0d", state, retired);
    check("halt_absorb_strobes", strobes, 0);
    check("halt_absorb_state", state, 6);
    check("halt_absorb_halt", halt, 1);
    check("halt_absorb_code", halt_code, 0);
    check("halt_absorb_retired", retired, exp_ret);

    // Reset in the middle of a memory wait.
    do_reset();
    run_vec(vecs[0]);
    dec_bus = 8'b1010_0000;
    if_ack = 1'b1;
    @(posedge clk); #1;
    if_ack = 1'b0;
    k = 0;
    while (!ls_req && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    check("midrst_mem_reached", ls_req, 1);
    check("midrst_pre_retired", retired, 1);
    @(negedge clk);
    rst_n = 1'b0; #1;
    check("midrst_async_outputs", {if_req, ir_we, ls_req, rf_we, csr_we, pc_we, trap_we, halt, halt_code, state}, 0);
    check("midrst_async_retired", retired, 0);
    if_ack = 1'b1; ls_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_held_outputs", {if_req, ir_we, ls_req, rf_we, csr_we, pc_we, trap_we, halt, halt_code, state}, 0);
    if_ack = 1'b0; ls_ack = 1'b0; dec_bus = '0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    $display("seq mid_op_reset: if_req %0d, retired %0d", if_req, retired);
    check("midrst_post_if_req", if_req, 1);
    check("midrst_post_retired", retired, 0);
    check("midrst_post_state", state, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
